// File: rtl/cnn_fc_pkg.sv
// Shared definitions for the fully-connected layer engine: FSM states,
// width helper and the accumulator-to-activation saturation function.
package cnn_fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIAS,
        ST_MAC,
        ST_DRAIN,
        ST_DONE
    } fc_state_e;

    // Widest accumulator the saturation helper handles.
    localparam int unsigned SAT_W = 64;

    function automatic int unsigned clog2w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             data_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output-neuron lane: bias preload, full-precision MAC, floor shift,
// saturation and (when FC_RELU_EN is defined) fused ReLU.
module fc_mac_lane
    import cnn_fc_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned ACC_W     = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_bias,
    input  logic [DATA_W-1:0] bias_in,
    input  logic              mac_en,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w_in,
    output logic [DATA_W-1:0] result
);

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    shifted;

    assign prod    = signed'(x_in) * signed'(w_in);
    assign shifted = acc_q >>> FRAC_BITS;

    always_comb begin
        acc_d = acc_q;
        if (load_bias) begin
            acc_d = ACC_W'(signed'(bias_in)) <<< FRAC_BITS;
        end else if (mac_en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_comb begin
        result = DATA_W'(saturate(SAT_W'(shifted), DATA_W));
`ifdef FC_RELU_EN
        if (result[DATA_W-1]) begin
            result = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer: buffers one input vector, then computes LANES neurons
// per group against banked weights and streams results. Optional FC_RELU_EN.
module fc_layer_engine
    import cnn_fc_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned IN_SIZE   = 120,
    parameter int unsigned OUT_SIZE  = 10,
    parameter int unsigned LANES     = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_W-1:0]                      in_data,
    input  logic                                   wt_we,
    input  logic [clog2w(IN_SIZE*OUT_SIZE)-1:0]    wt_addr,
    input  logic [DATA_W-1:0]                      wt_data,
    input  logic                                   bias_we,
    input  logic [clog2w(OUT_SIZE)-1:0]            bias_addr,
    input  logic [DATA_W-1:0]                      bias_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_W-1:0]                      out_data,
    output logic [clog2w(OUT_SIZE)-1:0]            out_idx,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned GROUPS = (OUT_SIZE + LANES - 1) / LANES;
    localparam int unsigned BANK_D = GROUPS * IN_SIZE;
    localparam int unsigned BA_W   = clog2w(OUT_SIZE);
    localparam int unsigned XA_W   = clog2w(IN_SIZE);
    localparam int unsigned CNT_W  = clog2w(IN_SIZE + 1);
    localparam int unsigned BK_W   = clog2w(BANK_D);
    localparam int unsigned LS_W   = clog2w(LANES);
    localparam int unsigned LB_W   = clog2w(LANES);
    localparam int unsigned OB_W   = clog2w(GROUPS * LANES + 1);
    localparam int unsigned WB_W   = clog2w(BANK_D + 1);

    fc_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OB_W-1:0]   o_base_q, o_base_d;
    logic [WB_W-1:0]   w_base_q, w_base_d;
    logic [LS_W-1:0]   lane_sel_q, lane_sel_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] x_rd_q, x_rd_d;
    logic [DATA_W-1:0] w_rd_q [LANES];
    logic [DATA_W-1:0] w_rd_d [LANES];

    logic [DATA_W-1:0] x_buf    [IN_SIZE];
    logic [DATA_W-1:0] wt_mem   [LANES][BANK_D];
    logic [DATA_W-1:0] bias_mem [OUT_SIZE];

    logic [DATA_W-1:0] bias_lane [LANES];
    logic [DATA_W-1:0] lane_res  [LANES];
    logic              load_bias;
    logic              x_we;
    logic [OB_W-1:0]   cur_o;
    logic              last_in_group;

    // Host weight address o*IN_SIZE+i is re-mapped to bank o%LANES, row (o/LANES)*IN_SIZE+i.
    logic [31:0] wa32, wo32, wi32, wbank32, wbaddr32;
    logic        wt_we_ok, bias_we_ok;

    assign wa32       = 32'(wt_addr);
    assign wo32       = wa32 / IN_SIZE;
    assign wi32       = wa32 % IN_SIZE;
    assign wbank32    = wo32 % LANES;
    assign wbaddr32   = (wo32 / LANES) * IN_SIZE + wi32;
    assign wt_we_ok   = wt_we && (state_q == ST_IDLE) && (wa32 < 32'(IN_SIZE * OUT_SIZE));
    assign bias_we_ok = bias_we && (state_q == ST_IDLE) && (32'(bias_addr) < 32'(OUT_SIZE));

    assign cur_o         = o_base_q + OB_W'(lane_sel_q);
    assign last_in_group = (lane_sel_q == LS_W'(LANES - 1)) || (cur_o == OB_W'(OUT_SIZE - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        o_base_d   = o_base_q;
        w_base_d   = w_base_q;
        lane_sel_d = lane_sel_q;
        rd_valid_d = 1'b0;
        load_bias  = 1'b0;
        x_we       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    o_base_d = '0;
                    w_base_d = '0;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_we = 1'b1;
                    if (cnt_q == CNT_W'(IN_SIZE - 1)) begin
                        state_d = ST_BIAS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_BIAS: begin
                load_bias = 1'b1;
                state_d   = ST_MAC;
                cnt_d     = '0;
            end
            ST_MAC: begin
                // Read issued at count k is accumulated one cycle later, hence IN_SIZE+1 cycles.
                if (cnt_q == CNT_W'(IN_SIZE)) begin
                    state_d    = ST_DRAIN;
                    lane_sel_d = '0;
                end else begin
                    rd_valid_d = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_in_group) begin
                        lane_sel_d = '0;
                        if (o_base_q + OB_W'(LANES) >= OB_W'(OUT_SIZE)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d  = ST_BIAS;
                            o_base_d = o_base_q + OB_W'(LANES);
                            w_base_d = w_base_q + WB_W'(IN_SIZE);
                        end
                    end else begin
                        lane_sel_d = lane_sel_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        x_rd_d = x_buf[XA_W'(cnt_q)];
        for (int unsigned l = 0; l < LANES; l++) begin
            w_rd_d[l]    = wt_mem[l][BK_W'(w_base_q + WB_W'(cnt_q))];
            bias_lane[l] = ((o_base_q + OB_W'(l)) < OB_W'(OUT_SIZE)) ?
                           bias_mem[BA_W'(o_base_q + OB_W'(l))] : '0;
        end
    end

    assign out_data = (state_q == ST_DRAIN) ? lane_res[lane_sel_q] : '0;
    assign out_idx  = (state_q == ST_DRAIN) ? BA_W'(cur_o) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            o_base_q   <= '0;
            w_base_q   <= '0;
            lane_sel_q <= '0;
            rd_valid_q <= 1'b0;
            x_rd_q     <= '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                w_rd_q[l] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_base_q   <= o_base_d;
            w_base_q   <= w_base_d;
            lane_sel_q <= lane_sel_d;
            rd_valid_q <= rd_valid_d;
            x_rd_q     <= x_rd_d;
            for (int unsigned l = 0; l < LANES; l++) begin
                w_rd_q[l] <= w_rd_d[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (x_we) begin
            x_buf[XA_W'(cnt_q)] <= in_data;
        end
        if (wt_we_ok) begin
            wt_mem[LB_W'(wbank32)][BK_W'(wbaddr32)] <= wt_data;
        end
        if (bias_we_ok) begin
            bias_mem[bias_addr] <= bias_data;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fc_mac_lane #(
            .DATA_W   (DATA_W),
            .FRAC_BITS(FRAC_BITS),
            .ACC_W    (ACC_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load_bias(load_bias),
            .bias_in  (bias_lane[l]),
            .mac_en   (rd_valid_q),
            .x_in     (x_rd_q),
            .w_in     (w_rd_q[l]),
            .result   (lane_res[l])
        );
    end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine (IN_SIZE=4, OUT_SIZE=3, LANES=2).
// Expected results are hand-computed; FC_RELU_EN selects the clamped values.
module tb_fc_layer_engine;

    localparam int unsigned DW = 16;
    localparam int unsigned IN = 4;
    localparam int unsigned OUT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        wt_we;
    logic [3:0]  wt_addr;
    logic [15:0] wt_data;
    logic        bias_we;
    logic [1:0]  bias_addr;
    logic [15:0] bias_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic        busy;
    logic        done;

    fc_layer_engine #(
        .DATA_W   (16),
        .FRAC_BITS(8),
        .ACC_W    (40),
        .IN_SIZE  (4),
        .OUT_SIZE (3),
        .LANES    (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .wt_we    (wt_we),
        .wt_addr  (wt_addr),
        .wt_data  (wt_data),
        .bias_we  (bias_we),
        .bias_addr(bias_addr),
        .bias_data(bias_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   bp_mode = 1'b0;
    int   done_cnt = 0;
    int   bcnt = 0;
    int   last_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Busy-cycle and done-pulse watcher.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                bcnt = 0;
            end else begin
                if (busy) bcnt++;
                if (done) begin
                    done_cnt++;
                    last_lat = bcnt;
                    bcnt = 0;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on each handshake, optionally stalling.
    initial begin
        exp_t        e;
        logic [15:0] cap_d;
        logic [1:0]  cap_i;
        int          hold;
        hold = 0;
        cap_d = '0;
        cap_i = '0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 0;
                out_ready = !bp_mode;
            end else if (out_valid) begin
                if (bp_mode && hold < 5) begin
                    if (hold == 0) begin
                        cap_d = out_data;
                        cap_i = out_idx;
                    end else begin
                        check("hold_data", 32'(out_data), 32'(cap_d));
                        check("hold_idx", 32'(out_idx), 32'(cap_i));
                    end
                    out_ready = 1'b0;
                    hold++;
                end else begin
                    if (bp_mode) check("hold_final", 32'(out_data), 32'(cap_d));
                    out_ready = 1'b1;
                    hold = 0;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got idx %0d data %0h expected none", out_idx, out_data);
                    end else begin
                        e = q.pop_front();
                        check("out_idx", 32'(out_idx), 32'(e.idx));
                        check("out_data", 32'(out_data), 32'(e.data));
                    end
                end
            end else begin
                out_ready = !bp_mode;
            end
        end
    end

    task automatic load_params(input logic [15:0] w, input logic [15:0] wstep,
                               input logic [15:0] b, input logic [15:0] bstep);
        for (int a = 0; a < 12; a++) begin
            @(negedge clk);
            wt_we = 1'b1;
            wt_addr = 4'(a);
            wt_data = w + 16'(a) * wstep;
        end
        @(negedge clk);
        wt_we = 1'b0;
        for (int o = 0; o < 3; o++) begin
            @(negedge clk);
            bias_we = 1'b1;
            bias_addr = 2'(o);
            bias_data = b + 16'(o) * bstep;
        end
        @(negedge clk);
        bias_we = 1'b0;
    endtask

    task automatic run(input logic [15:0] x0, input logic [15:0] xstep,
                       input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                       input int n_exp, input bit toggle, input bit protect, input bit rst_mid);
        exp_t e;
        int   d0, i, guard, t;
        bit   hs;
        logic [15:0] ev [3];
        ev[0] = e0; ev[1] = e1; ev[2] = e2;
        for (int k = 0; k < n_exp; k++) begin
            e.idx = 2'(k);
            e.data = ev[k];
            q.push_back(e);
        end
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        guard = 0;
        while (i < IN && guard < 200) begin
            in_valid = !(toggle && (guard % 2 == 1));
            in_data = x0 + 16'(i) * xstep;
            hs = in_valid && in_ready;
            @(posedge clk);
            if (hs) i++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (i < IN) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got %0d beats expected %0d", i, IN);
        end
        if (protect) begin
            @(negedge clk);
            wt_we = 1'b1; wt_addr = 4'd8; wt_data = 16'h7F00;
            bias_we = 1'b1; bias_addr = 2'd2; bias_data = 16'h7F00;
            start = 1'b1;
            @(negedge clk);
            wt_we = 1'b0; bias_we = 1'b0; start = 1'b0;
        end
        if (rst_mid) begin
            t = 0;
            while (q.size() != 0 && t < 300) begin
                @(negedge clk);
                t++;
            end
            check("grp0_drained", 32'(q.size()), 32'd0);
            repeat (3) @(negedge clk);
            reset = 1'b1;
            #1;
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_out_idx", 32'(out_idx), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            @(negedge clk);
            reset = 1'b0;
            repeat (30) @(negedge clk);
            check("rst_no_done", 32'(done_cnt - d0), 32'd0);
            check("rst_no_out", 32'(q.size()), 32'd0);
        end else begin
            t = 0;
            while (done_cnt == d0 && t < 400) begin
                @(negedge clk);
                t++;
            end
            repeat (3) @(negedge clk);
            check("done_pulses", 32'(done_cnt - d0), 32'd1);
            check("busy_after", 32'(busy), 32'd0);
            check("queue_drained", 32'(q.size()), 32'd0);
        end
    endtask

    logic [15:0] r_sat_neg, r_neg_bias, r_floor;

    initial begin
`ifdef FC_RELU_EN
        r_sat_neg = 16'h0000; r_neg_bias = 16'h0000; r_floor = 16'h0000;
`else
        r_sat_neg = 16'h8000; r_neg_bias = 16'hFE00; r_floor = 16'hFFFF;
`endif
        reset = 1'b1;
        start = 1'b0; in_valid = 1'b0; in_data = '0;
        wt_we = 1'b0; wt_addr = '0; wt_data = '0;
        bias_we = 1'b0; bias_addr = '0; bias_data = '0;
        repeat (2) @(negedge clk);
        check("init_in_ready", 32'(in_ready), 32'd0);
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_out_data", 32'(out_data), 32'd0);
        check("init_out_idx", 32'(out_idx), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        check("init_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Basic: 1.0 + 4*(1.0*0.5) = 3.0
        load_params(16'h0080, 16'h0000, 16'h0100, 16'h0000);
        run(16'h0100, 16'h0000, 16'h0300, 16'h0300, 16'h0300, 3, 0, 0, 0);
        check("latency", 32'(last_lat), 32'd20);

        // Distinct x, weights and biases exercise bank decode and input ordering.
        load_params(16'h0010, 16'h0010, 16'h0000, 16'h0100);
        run(16'h0100, 16'h0100, 16'h01E0, 16'h0560, 16'h08E0, 3, 0, 0, 0);

        // Saturation in both directions.
        load_params(16'h7F00, 16'h0000, 16'h0100, 16'h0000);
        run(16'h7F00, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 3, 0, 0, 0);
        load_params(16'h8100, 16'h0000, 16'h0100, 16'h0000);
        run(16'h7F00, 16'h0000, r_sat_neg, r_sat_neg, r_sat_neg, 3, 0, 0, 0);

        // Negative bias, and floor rounding of a tiny negative sum (-4/256 -> -1).
        load_params(16'h0080, 16'h0000, 16'hFE00, 16'h0000);
        run(16'h0000, 16'h0000, r_neg_bias, r_neg_bias, r_neg_bias, 3, 0, 0, 0);
        load_params(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        run(16'h0001, 16'h0000, r_floor, r_floor, r_floor, 3, 0, 0, 0);

        // Output backpressure, then input stalls.
        load_params(16'h0080, 16'h0000, 16'h0100, 16'h0000);
        @(negedge clk);
        bp_mode = 1'b1;
        run(16'h0100, 16'h0000, 16'h0300, 16'h0300, 16'h0300, 3, 0, 0, 0);
        bp_mode = 1'b0;
        run(16'h0100, 16'h0000, 16'h0300, 16'h0300, 16'h0300, 3, 1, 0, 0);

        // Writes and start during MAC must be dropped.
        run(16'h0100, 16'h0000, 16'h0300, 16'h0300, 16'h0300, 3, 0, 1, 0);
        run(16'h0100, 16'h0000, 16'h0300, 16'h0300, 16'h0300, 3, 0, 0, 0);

        // Reset in group 1, then a fresh inference.
        run(16'h0100, 16'h0000, 16'h0300, 16'h0300, 16'h0300, 2, 0, 0, 1);
        run(16'h0100, 16'h0000, 16'h0300, 16'h0300, 16'h0300, 3, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
